// File: rtl/code_lock_pkg.sv
// Shared types and helpers for the code_lock combination lock.
package code_lock_pkg;

  localparam logic [1:0] ST_LOCKED_ENC   = 2'd0;
  localparam logic [1:0] ST_UNLOCKED_ENC = 2'd1;
  localparam logic [1:0] ST_PROGRAM_ENC  = 2'd2;
  localparam logic [1:0] ST_LOCKOUT_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_LOCKED   = ST_LOCKED_ENC,
    ST_UNLOCKED = ST_UNLOCKED_ENC,
    ST_PROGRAM  = ST_PROGRAM_ENC,
    ST_LOCKOUT  = ST_LOCKOUT_ENC
  } code_lock_state_t;

  // Bits needed to hold the values 0..n inclusive (never less than one bit).
  function automatic int cnt_w(input int n);
    if (n < 1) return 1;
    else return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/entry_shift.sv
// Symbol entry shift register with saturating count and sticky overflow flag.
module entry_shift
  import code_lock_pkg::*;
#(
  parameter int SYM_W    = 1,
  parameter int CODE_LEN = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            zap,
  input  logic                            shift,
  input  logic [SYM_W-1:0]                sym,
  output logic [CODE_LEN*SYM_W-1:0]       entry,
  output logic [cnt_w(CODE_LEN)-1:0]      entry_count,
  output logic                            overflow
);

  localparam int EW = CODE_LEN * SYM_W;
  localparam int CW = cnt_w(CODE_LEN);

  // Shift in one symbol per accepted sym_valid; zap wipes the whole entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      entry       <= '0;
      entry_count <= '0;
      overflow    <= 1'b0;
    end else if (zap) begin
      entry       <= '0;
      entry_count <= '0;
      overflow    <= 1'b0;
    end else if (shift) begin
      entry <= (entry << SYM_W) | EW'(sym);
      if (entry_count == CW'(CODE_LEN)) overflow <= 1'b1;
      else entry_count <= entry_count + CW'(1);
    end else begin
      entry       <= entry;
      entry_count <= entry_count;
      overflow    <= overflow;
    end
  end

endmodule

// File: rtl/code_lock.sv
// Multi-symbol combination lock with reprogrammable code.
// Define CODE_LOCK_LOCKOUT_EN to enable the attempt counter and timed lockout.
module code_lock
  import code_lock_pkg::*;
#(
  parameter int                          SYM_W          = 1,
  parameter int                          CODE_LEN       = 8,
  parameter logic [CODE_LEN*SYM_W-1:0]   DEFAULT_CODE   = '0,
  parameter int                          MAX_TRIES      = 3,
  parameter int                          LOCKOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           sym_valid,
  input  logic [SYM_W-1:0]               sym,
  input  logic                           enter,
  input  logic                           clear,
  input  logic                           prog,
  input  logic                           relock,
  output logic                           locked,
  output logic                           lockout,
  output logic                           accept,
  output logic                           reject,
  output logic [CODE_LEN*SYM_W-1:0]      entry,
  output logic [cnt_w(CODE_LEN)-1:0]     entry_count,
  output logic [cnt_w(MAX_TRIES)-1:0]    fail_count
);

  localparam int EW = CODE_LEN * SYM_W;
  localparam int CW = cnt_w(CODE_LEN);
  localparam int FW = cnt_w(MAX_TRIES);
  localparam int TW = cnt_w(LOCKOUT_CYCLES);

  code_lock_state_t state_r, state_s;
  logic [EW-1:0]    code_r, code_s;
  logic [FW-1:0]    fail_r, fail_s;
  logic [TW-1:0]    timer_r, timer_s;
  logic             accept_s, reject_s, zap_s, shift_s, valid_s, overflow_s;

  entry_shift #(.SYM_W(SYM_W), .CODE_LEN(CODE_LEN)) u_entry (
    .clk         (clk),
    .reset_n     (reset_n),
    .zap         (zap_s),
    .shift       (shift_s),
    .sym         (sym),
    .entry       (entry),
    .entry_count (entry_count),
    .overflow    (overflow_s)
  );

  assign valid_s    = (entry_count == CW'(CODE_LEN)) && !overflow_s;
  assign fail_count = fail_r;

  // Next-state logic; input priority is enter, clear, relock/prog, sym_valid.
  always_comb begin
    state_s  = state_r;
    code_s   = code_r;
    fail_s   = fail_r;
    timer_s  = timer_r;
    accept_s = 1'b0;
    reject_s = 1'b0;
    zap_s    = 1'b0;
    shift_s  = 1'b0;
    case (state_r)
      ST_LOCKED: begin
        if (enter) begin
          zap_s = 1'b1;
          if (valid_s && (entry == code_r)) begin
            accept_s = 1'b1;
            fail_s   = '0;
            state_s  = ST_UNLOCKED;
          end else begin
            reject_s = 1'b1;
`ifdef CODE_LOCK_LOCKOUT_EN
            fail_s = fail_r + FW'(1);
            if (fail_r == FW'(MAX_TRIES - 1)) begin
              state_s = ST_LOCKOUT;
              timer_s = TW'(LOCKOUT_CYCLES - 1);
            end else begin
              state_s = ST_LOCKED;
            end
`endif
          end
        end else if (clear) begin
          zap_s = 1'b1;
        end else begin
          shift_s = sym_valid;
        end
      end
      ST_UNLOCKED: begin
        if (enter) begin
          zap_s    = 1'b1;
          reject_s = 1'b1;
        end else if (clear) begin
          zap_s = 1'b1;
        end else if (relock) begin
          state_s = ST_LOCKED;
        end else if (prog) begin
          state_s = ST_PROGRAM;
        end else begin
          shift_s = sym_valid;
        end
      end
      ST_PROGRAM: begin
        if (enter) begin
          zap_s = 1'b1;
          if (valid_s) begin
            code_s   = entry;
            accept_s = 1'b1;
            state_s  = ST_UNLOCKED;
          end else begin
            reject_s = 1'b1;
          end
        end else if (clear) begin
          zap_s = 1'b1;
        end else begin
          shift_s = sym_valid;
        end
      end
      ST_LOCKOUT: begin
        // Only reachable with lockout enabled; every input is ignored here.
        if (timer_r == '0) begin
          state_s = ST_LOCKED;
          fail_s  = '0;
        end else begin
          timer_s = timer_r - TW'(1);
        end
      end
      default: begin
        state_s = ST_LOCKED;
      end
    endcase
  end

  // State, stored code, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_LOCKED;
      code_r  <= DEFAULT_CODE;
      fail_r  <= '0;
      timer_r <= '0;
      accept  <= 1'b0;
      reject  <= 1'b0;
      locked  <= 1'b1;
      lockout <= 1'b0;
    end else begin
      state_r <= state_s;
      code_r  <= code_s;
      fail_r  <= fail_s;
      timer_r <= timer_s;
      accept  <= accept_s;
      reject  <= reject_s;
      locked  <= !((state_s == ST_UNLOCKED) || (state_s == ST_PROGRAM));
      lockout <= (state_s == ST_LOCKOUT);
    end
  end

endmodule
